// File: rtl/riscv_v_mul_pipe.sv
// rtl/riscv_v_mul_pipe.sv - elastic pipelined SIMD integer multiplier (vmul/vmulh/vmulhu/vmulhsu)
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   flush              drop every in-flight operation (highest priority)
//   in_valid/in_ready  request handshake; src_a (vs2), src_b (vs1), osize_vector, op, in_tag
//   out_valid/out_ready result handshake; result, out_tag, out_illegal
//   busy               any pipeline stage holds a valid operation
module riscv_v_mul_pipe #(
  parameter int DATA_WIDTH  = 128,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_WIDTH   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  input  logic [3:0]            osize_vector,
  input  logic [1:0]            op,
  input  logic [TAG_WIDTH-1:0]  in_tag,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [TAG_WIDTH-1:0]  out_tag,
  output logic                  out_illegal,
  output logic                  busy
);

  if ((DATA_WIDTH % 64) != 0 || PIPE_STAGES < 1 || PIPE_STAGES > 4) begin : g_param_check
    $fatal(1, "riscv_v_mul_pipe: DATA_WIDTH must be a multiple of 64 and PIPE_STAGES in 1..4");
  end

  localparam int NW = 4;

  logic                            w_a_signed;
  logic                            w_b_signed;
  logic                            w_hi;
  logic                            w_osize_legal;
  logic [NW-1:0][DATA_WIDTH-1:0]   w_res_sew;
  logic [DATA_WIDTH-1:0]           w_res;

  assign w_a_signed    = (op == 2'b01) || (op == 2'b11);
  assign w_b_signed    = (op == 2'b01);
  assign w_hi          = (op != 2'b00);
  assign w_osize_legal = (osize_vector != 4'd0) &&
                         ((osize_vector & (osize_vector - 4'd1)) == 4'd0);

  // One lane array per element width; the one-hot osize picks which one is used.
  // Each lane multiplies magnitudes unsigned and re-applies the sign afterwards,
  // so -2^(SEW-1) maps to magnitude 2^(SEW-1) and the product stays exact.
  for (genvar w = 0; w < NW; w++) begin : g_sew
    localparam int SEW   = 8 << w;
    localparam int LANES = DATA_WIDTH / SEW;
    for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [SEW-1:0]   w_a;
      logic [SEW-1:0]   w_b;
      logic             w_a_neg;
      logic             w_b_neg;
      logic [SEW-1:0]   w_a_mag;
      logic [SEW-1:0]   w_b_mag;
      logic [2*SEW-1:0] w_p_u;
      logic [2*SEW-1:0] w_p;

      assign w_a     = src_a[l*SEW +: SEW];
      assign w_b     = src_b[l*SEW +: SEW];
      assign w_a_neg = w_a_signed & w_a[SEW-1];
      assign w_b_neg = w_b_signed & w_b[SEW-1];
      assign w_a_mag = w_a_neg ? -w_a : w_a;
      assign w_b_mag = w_b_neg ? -w_b : w_b;
      assign w_p_u   = {{SEW{1'b0}}, w_a_mag} * {{SEW{1'b0}}, w_b_mag};
      assign w_p     = (w_a_neg ^ w_b_neg) ? -w_p_u : w_p_u;
      assign w_res_sew[w][l*SEW +: SEW] = w_hi ? w_p[2*SEW-1:SEW] : w_p[SEW-1:0];
    end
  end

  always_comb begin
    w_res = '0;
    if (w_osize_legal) begin
      for (int w = 0; w < NW; w++) begin
        if (osize_vector[w]) w_res = w_res_sew[w];
      end
    end
  end

  // Pipeline stages: index PIPE_STAGES-1 is the output register.
  logic [PIPE_STAGES-1:0] r_valid;
  logic [PIPE_STAGES-1:0] r_ill;
  logic [DATA_WIDTH-1:0]  r_data [PIPE_STAGES];
  logic [TAG_WIDTH-1:0]   r_tag  [PIPE_STAGES];
  logic [PIPE_STAGES:0]   w_rdy;

  // A stage may load when it is empty or its own contents move on this cycle.
  always_comb begin
    w_rdy = '0;
    w_rdy[PIPE_STAGES] = out_ready;
    for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
      w_rdy[k] = !r_valid[k] | w_rdy[k+1];
    end
  end

  assign in_ready = w_rdy[0] & !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_ill   <= '0;
      for (int k = 0; k < PIPE_STAGES; k++) begin
        r_data[k] <= '0;
        r_tag[k]  <= '0;
      end
    end else if (flush) begin
      r_valid <= '0;
    end else begin
      if (w_rdy[0]) begin
        r_valid[0] <= in_valid;
        if (in_valid) begin
          r_data[0] <= w_res;
          r_tag[0]  <= in_tag;
          r_ill[0]  <= !w_osize_legal;
        end
      end
      for (int k = 1; k < PIPE_STAGES; k++) begin
        if (w_rdy[k]) begin
          r_valid[k] <= r_valid[k-1];
          if (r_valid[k-1]) begin
            r_data[k] <= r_data[k-1];
            r_tag[k]  <= r_tag[k-1];
            r_ill[k]  <= r_ill[k-1];
          end
        end
      end
    end
  end

  assign out_valid   = r_valid[PIPE_STAGES-1];
  assign result      = r_data[PIPE_STAGES-1];
  assign out_tag     = r_tag[PIPE_STAGES-1];
  assign out_illegal = r_ill[PIPE_STAGES-1];
  assign busy        = |r_valid;

endmodule

// File: tb/tb_riscv_v_mul_pipe.sv
// tb/tb_riscv_v_mul_pipe.sv - self-checking bench for riscv_v_mul_pipe
module tb_riscv_v_mul_pipe;

  localparam int DW = 128;
  localparam int P  = 3;
  localparam int TW = 5;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] src_a;
  logic [DW-1:0] src_b;
  logic [3:0]    osize_vector;
  logic [1:0]    op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic [TW-1:0] out_tag;
  logic          out_illegal;
  logic          busy;

  riscv_v_mul_pipe #(.DATA_WIDTH(DW), .PIPE_STAGES(P), .TAG_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .src_a(src_a), .src_b(src_b), .osize_vector(osize_vector), .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .result(result), .out_tag(out_tag),
    .out_illegal(out_illegal), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] res;
    logic [TW-1:0] tag;
    logic          ill;
  } exp_t;

  typedef struct {
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [3:0]    osz;
    logic [1:0]    op;
    logic [DW-1:0] res;
    logic          ill;
  } vec_t;

  exp_t          expq[$];
  int            n_checks;
  int            n_fail;
  int            n_recv;
  bit            last_acc;
  bit            held;
  logic [DW-1:0] held_res;
  logic [TW-1:0] held_tag;
  logic          held_ill;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: sign/zero extend each lane to 128 bits and multiply modulo 2^128.
  function automatic logic [DW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                            input logic [3:0] osz, input logic [1:0] opc);
    logic [127:0] r, mask, av, bv, p, half;
    int sew;
    r = '0;
    case (osz)
      4'b0001: sew = 8;
      4'b0010: sew = 16;
      4'b0100: sew = 32;
      4'b1000: sew = 64;
      default: return '0;
    endcase
    mask = (128'd1 << sew) - 128'd1;
    for (int l = 0; l < DW / sew; l++) begin
      av = (a >> (l * sew)) & mask;
      bv = (b >> (l * sew)) & mask;
      if ((opc == 2'b01 || opc == 2'b11) && av[sew-1]) av = av | ~mask;
      if (opc == 2'b01 && bv[sew-1]) bv = bv | ~mask;
      p = av * bv;
      half = (opc == 2'b00) ? (p & mask) : ((p >> sew) & mask);
      r = r | (half << (l * sew));
    end
    return r;
  endfunction

  // Called at a negedge with inputs set; predicts the coming edge and ends at the next negedge.
  task automatic step();
    exp_t e;
    bit   cons;
    #1;
    check("in_ready", in_ready, !flush && !(expq.size() == P && !out_ready));
    check("busy", busy, expq.size() != 0);
    if (expq.size() == 0) check("idle_out_valid", out_valid, 0);
    if (held) begin
      check("stall_valid", out_valid, 1);
      check("stall_result", result, held_res);
      check("stall_tag", out_tag, held_tag);
      check("stall_illegal", out_illegal, held_ill);
    end
    last_acc = in_valid && in_ready;
    cons = out_valid && out_ready && !flush;
    if (cons && expq.size() > 0) begin
      e = expq.pop_front();
      check("result", result, e.res);
      check("out_tag", out_tag, e.tag);
      check("out_illegal", out_illegal, e.ill);
      n_recv++;
    end
    if (flush) expq.delete();
    if (last_acc) begin
      e.res = ref_mul(src_a, src_b, osize_vector, op);
      e.tag = in_tag;
      e.ill = !(osize_vector == 4'b0001 || osize_vector == 4'b0010 ||
                osize_vector == 4'b0100 || osize_vector == 4'b1000);
      expq.push_back(e);
    end
    held = out_valid && !out_ready && !flush;
    held_res = result;
    held_tag = out_tag;
    held_ill = out_illegal;
    @(negedge clk);
  endtask

  task automatic rand_op(input logic [TW-1:0] tag);
    int s;
    src_a = {$urandom, $urandom, $urandom, $urandom};
    src_b = {$urandom, $urandom, $urandom, $urandom};
    if ($urandom_range(0, 7) == 0) src_a = {2{64'h8000_0000_0000_0000}};
    if ($urandom_range(0, 7) == 0) src_b = {2{64'h8000_0000_0000_0000}};
    s = $urandom_range(0, 8);
    osize_vector = (s < 8) ? 4'(1 << (s % 4)) : 4'($urandom_range(0, 15));
    op = 2'($urandom_range(0, 3));
    in_tag = tag;
  endtask

  task automatic drain();
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && expq.size() > 0; c++) step();
    check("drain_done", expq.size() == 0, 1);
  endtask

  vec_t vecs[12];
  bit   lat_ok;
  int   sent;
  int   recv0;

  initial begin
    n_checks = 0; n_fail = 0; n_recv = 0; held = 0; last_acc = 0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    src_a = '0; src_b = '0; osize_vector = 4'b0001; op = 2'b00; in_tag = '0;

    vecs[0]  = '{{16{8'hFD}}, {16{8'h05}}, 4'b0001, 2'b01, {16{8'hFF}}, 1'b0};
    vecs[1]  = '{{16{8'hFD}}, {16{8'h05}}, 4'b0001, 2'b00, {16{8'hF1}}, 1'b0};
    vecs[2]  = '{{16{8'hFD}}, {16{8'h05}}, 4'b0001, 2'b10, {16{8'h04}}, 1'b0};
    vecs[3]  = '{{16{8'hFD}}, {16{8'hFD}}, 4'b0001, 2'b11, {16{8'hFD}}, 1'b0};
    vecs[4]  = '{{2{64'h8000_0000_0000_0000}}, {2{64'h8000_0000_0000_0000}}, 4'b1000, 2'b01,
                 {2{64'h4000_0000_0000_0000}}, 1'b0};
    vecs[5]  = '{{2{64'h8000_0000_0000_0000}}, {2{64'h8000_0000_0000_0000}}, 4'b1000, 2'b00,
                 '0, 1'b0};
    vecs[6]  = '{{2{64'h8000_0000_0000_0000}}, {2{64'h8000_0000_0000_0000}}, 4'b1000, 2'b10,
                 {2{64'h4000_0000_0000_0000}}, 1'b0};
    vecs[7]  = '{{4{32'hFFFF_FFFF}}, {4{32'h2}}, 4'b0100, 2'b10, {4{32'h1}}, 1'b0};
    vecs[8]  = '{{4{32'hFFFF_FFFF}}, {4{32'h2}}, 4'b0100, 2'b01, {4{32'hFFFF_FFFF}}, 1'b0};
    vecs[9]  = '{{DW{1'b1}}, {DW{1'b1}}, 4'b0101, 2'b00, '0, 1'b1};
    vecs[10] = '{{DW{1'b1}}, {8{16'h0003}}, 4'b0010, 2'b00, {8{16'hFFFD}}, 1'b0};
    vecs[11] = '{{DW{1'b1}}, {DW{1'b1}}, 4'b0000, 2'b01, '0, 1'b1};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_illegal", out_illegal, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Directed table: latency, values, tag echo
    for (int i = 0; i < 12; i++) begin
      src_a = vecs[i].a; src_b = vecs[i].b; osize_vector = vecs[i].osz; op = vecs[i].op;
      in_tag = TW'(i + 3); in_valid = 1'b1; out_ready = 1'b1;
      step();
      check("vec_accept", last_acc, 1);
      in_valid = 1'b0;
      lat_ok = 1'b1;
      for (int j = 0; j < P; j++) begin
        #1;
        if (out_valid !== (j == P - 1)) lat_ok = 1'b0;
        if (j == P - 1) begin
          check("vec_result", result, vecs[i].res);
          check("vec_tag", out_tag, TW'(i + 3));
          check("vec_illegal", out_illegal, vecs[i].ill);
        end
        step();
      end
      check("vec_latency", lat_ok, 1);
    end

    // Back-to-back stream, tags 0..19, random out_ready with a 6-cycle hold-off
    sent = 0;
    recv0 = n_recv;
    rand_op(TW'(0));
    for (int c = 0; c < 400 && (sent < 20 || expq.size() > 0); c++) begin
      in_valid = (sent < 20);
      out_ready = (c >= 4 && c < 10) ? 1'b0 : ($urandom_range(0, 2) != 0);
      step();
      if (last_acc) begin
        sent++;
        rand_op(TW'(sent));
      end
    end
    check("stream_count", n_recv - recv0, 20);

    // Flush with a stalled output and a pending request
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op(TW'(20 + i));
      step();
    end
    #1;
    check("pre_flush_valid", out_valid, 1);
    flush = 1'b1;
    out_ready = 1'b1;
    rand_op(TW'(30));
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("post_flush_busy", busy, 0);
    check("post_flush_valid", out_valid, 0);
    @(negedge clk);
    in_valid = 1'b1;
    rand_op(TW'(31));
    step();
    drain();

    // Asynchronous reset between edges
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_op(TW'(10 + i));
      step();
    end
    #1;
    check("pre_reset_valid", out_valid, 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_result", result, 0);
    check("async_rst_busy", busy, 0);
    expq.delete();
    held = 0;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();

    // Random traffic with occasional flush
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      rand_op(TW'($urandom_range(0, 31)));
      step();
    end
    flush = 1'b0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
